// File: rtl/sfp_pkg.sv
// -----------------------------------------------------------------------------
// sfp_pkg
// Shared definitions for the SFP row-normaliser slice.
//   SFP_BW / SFP_COL : default element width and row length
//   SUM_W            : width of the row-sum accumulator for the default sizes
//   SFP_SAT_MAX      : largest divisor the divider accepts (2^BW-1)
//   state_t          : sequencer FSM encoding
// -----------------------------------------------------------------------------
package sfp_pkg;

  localparam int unsigned SFP_BW  = 20;
  localparam int unsigned SFP_COL = 8;
  localparam int unsigned SUM_W   = SFP_BW + $clog2(SFP_COL);

  localparam logic [SFP_BW-1:0] SFP_SAT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    EMIT  = 3'd4
  } state_t;

endpackage

// File: rtl/sfp_row_buf.sv
// -----------------------------------------------------------------------------
// sfp_row_buf
// COL x BW register file holding one row of elements.
//   clk    : rising-edge clock
//   we     : write enable
//   waddr  : write slot
//   wdata  : element to store
//   raddr  : read slot (asynchronous read)
//   rdata  : element at raddr
// -----------------------------------------------------------------------------
module sfp_row_buf #(
  parameter  int unsigned BW  = 20,
  parameter  int unsigned COL = 8,
  localparam int unsigned AW  = $clog2(COL)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  logic [BW-1:0] mem [COL];

  // NOTE: storage is deliberately left without reset; every slot is written
  // before it is read, and a reset network on a register file only costs.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfp_norm_seq.sv
// -----------------------------------------------------------------------------
// sfp_norm_seq
// Row normaliser sequencer in front of sfp_custom_div. Collects COL elements,
// sums them, then divides each element by the (clamped) row sum one at a time
// and streams the quotients out in order, flagging the last one of the row.
//
// Optional feature: define SFP_ABS_EN to capture |x| instead of the raw value
// (the most negative input maps to 2^(BW-1)-1).
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_data: element input stream
//   div_strt                 : one-cycle start to the divider
//   div_busy/div_done        : divider status, done is a one-cycle pulse
//   div_valid/div_ans        : quotient and its validity (0 = divide by zero)
//   div_dividend/div_divisor : operands, stable from ISSUE to end of WAIT
//   out_valid/out_ready      : output handshake
//   out_data/out_last        : normalised element, last-of-row marker
// -----------------------------------------------------------------------------
module sfp_norm_seq
  import sfp_pkg::*;
#(
  parameter int unsigned BW  = SFP_BW,
  parameter int unsigned COL = SFP_COL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  output logic          div_strt,
  input  logic          div_busy,
  input  logic          div_done,
  input  logic          div_valid,
  output logic [BW-1:0] div_dividend,
  output logic [BW-1:0] div_divisor,
  input  logic [BW-1:0] div_ans,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic          out_last
);

  localparam int unsigned AW    = $clog2(COL);
  localparam int unsigned ACC_W = BW + AW;
  localparam logic [AW-1:0]    LAST_IDX = AW'(COL - 1);
  localparam logic [ACC_W-1:0] DIV_MAX  = ACC_W'({BW{1'b1}});

  state_t            state;
  logic [AW-1:0]     ld_cnt;
  logic [AW-1:0]     idx;
  logic [ACC_W-1:0]  sum_q;
  logic [ACC_W-1:0]  sum_next;
  logic [BW-1:0]     divisor_q;
  logic [BW-1:0]     in_mag;
  logic [BW-1:0]     rd_data;
  logic              accept;
  logic              div_phase;

  // Element conditioning on capture.
  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    in_mag = in_data;
`ifdef SFP_ABS_EN
    if (in_data[BW-1]) begin
      // -2^(BW-1) has no positive counterpart; saturate to the largest magnitude.
      if (in_data == {1'b1, {(BW-1){1'b0}}}) in_mag = {1'b0, {(BW-1){1'b1}}};
      else                                   in_mag = -in_data;
    end
`endif
  end

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign accept    = in_valid && in_ready;
  assign sum_next  = sum_q + ACC_W'(in_mag);
  assign div_phase = (state == ISSUE) || (state == WAIT);

  // Start is only offered while the divider is free; ISSUE simply holds otherwise.
  assign div_strt     = (state == ISSUE) && !div_busy;
  assign div_dividend = div_phase ? rd_data   : '0;
  assign div_divisor  = div_phase ? divisor_q : '0;

  sfp_row_buf #(
    .BW  (BW),
    .COL (COL)
  ) u_row_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (ld_cnt),
    .wdata (in_mag),
    .raddr (idx),
    .rdata (rd_data)
  );

  // NOTE: sequential state is assigned with <= only, so every register in this
  // block samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ld_cnt    <= '0;
      idx       <= '0;
      sum_q     <= '0;
      divisor_q <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            // First element restarts the accumulator for the new row.
            sum_q  <= ACC_W'(in_mag);
            ld_cnt <= ld_cnt + 1'b1;
            state  <= LOAD;
          end
        end

        LOAD: begin
          if (accept) begin
            sum_q  <= sum_next;
            // COL is a power of two, so the increment wraps to 0 on the last slot.
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == LAST_IDX) begin
              divisor_q <= (sum_next > DIV_MAX) ? {BW{1'b1}} : sum_next[BW-1:0];
              idx       <= '0;
              state     <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (!div_busy) state <= WAIT;
        end

        WAIT: begin
          if (div_done) begin
            // A zero row sum reports invalid; normalise such rows to zero.
            out_data  <= div_valid ? div_ans : '0;
            out_last  <= (idx == LAST_IDX);
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end

        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ISSUE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_norm_seq.sv
// -----------------------------------------------------------------------------
// tb_sfp_norm_seq
// Directed bench for sfp_norm_seq with a latency-5 divider stub whose answer
// is {dividend[9:0], divisor[9:0]} and whose valid is divisor != 0.
// -----------------------------------------------------------------------------
module tb_sfp_norm_seq;

  localparam int unsigned BW  = 20;
  localparam int unsigned COL = 8;
  localparam logic [BW-1:0] SAT = 20'hFFFFF;

  typedef logic [BW-1:0] row_t [COL];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          div_strt;
  logic          div_busy;
  logic          div_done = 1'b0;
  logic          div_valid = 1'b0;
  logic [BW-1:0] div_dividend;
  logic [BW-1:0] div_divisor;
  logic [BW-1:0] div_ans = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
  logic          out_last;

  int tests = 0;
  int fails = 0;

  sfp_norm_seq #(.BW(BW), .COL(COL)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .div_strt     (div_strt),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_valid    (div_valid),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_ans      (div_ans),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Divider stub: not reset by rst, so a start issued before a reset still
  // produces a stray done pulse afterwards.
  int            stub_cnt = 0;
  logic [BW-1:0] stub_a = '0;
  logic [BW-1:0] stub_b = '0;
  logic          force_busy = 1'b0;

  assign div_busy = force_busy || (stub_cnt != 0);

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        div_done  <= 1'b1;
        div_valid <= (stub_b != '0);
        div_ans   <= {stub_a[9:0], stub_b[9:0]};
      end
    end else if (div_strt) begin
      stub_a   <= div_dividend;
      stub_b   <= div_divisor;
      stub_cnt <= 5;
    end
  end

  // Transaction monitor, sampled mid-cycle.
  logic [BW-1:0] st_dvd[$];
  logic [BW-1:0] st_dvs[$];
  logic [BW-1:0] o_data[$];
  logic          o_last[$];
  int            acc_q[$];
  int            last_q[$];
  int            strt_busy_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (div_strt && div_busy) strt_busy_cnt++;
      if (div_strt && !div_busy) begin
        st_dvd.push_back(div_dividend);
        st_dvs.push_back(div_divisor);
      end
      if (out_valid && out_ready) begin
        o_data.push_back(out_data);
        o_last.push_back(out_last);
        if (out_last) last_q.push_back(cyc);
      end
      if (in_valid && in_ready) acc_q.push_back(cyc);
    end
  end

  // Reference model pieces.
  function automatic logic [BW-1:0] cap(input logic [BW-1:0] x);
`ifdef SFP_ABS_EN
    if (x == {1'b1, {(BW-1){1'b0}}}) return {1'b0, {(BW-1){1'b1}}};
    if (x[BW-1]) return -x;
`endif
    return x;
  endfunction

  function automatic logic [BW-1:0] ans_of(input logic [BW-1:0] a, input logic [BW-1:0] b);
    if (b == '0) return '0;
    return {a[9:0], b[9:0]};
  endfunction

  task automatic clear_queues();
    st_dvd.delete(); st_dvs.delete(); o_data.delete(); o_last.delete();
    acc_q.delete(); last_q.delete();
  endtask

  task automatic send_row(input row_t r);
    for (int i = 0; i < COL; i++) begin
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = r[i];
      @(negedge clk);
      while (!in_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        tests++; fails++;
        $display("FAIL send_row_timeout: element %0d not accepted, in_ready=%b expected 1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n, input string name);
    int guard;
    guard = 0;
    while (o_data.size() < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (o_data.size() < n) begin
      fails++;
      $display("FAIL %s_timeout: got %0d outputs, expected %0d", name, o_data.size(), n);
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, out_last, div_strt} !== 3'b000 || out_data !== '0 ||
        div_dividend !== '0 || div_divisor !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b last=%b strt=%b data=%h dvd=%h dvs=%h, expected all 0",
               out_valid, out_last, div_strt, out_data, div_dividend, div_divisor);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  // Rows 1-3: plain normalisation, all-zero row, clamped divisor.
  task automatic test_normalise();
    row_t          rows [3];
    logic [BW-1:0] dvs  [3];
    rows[0] = '{20'd86, 20'd4, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd10};
    rows[1] = '{default: 20'd0};
    rows[2] = '{default: 20'h80000};
    dvs[0]  = 20'd100;
    dvs[1]  = 20'd0;
    dvs[2]  = SAT;
    for (int r = 0; r < 3; r++) begin
      clear_queues();
      send_row(rows[r]);
      wait_outs(COL, "norm");
      tests++;
      if (st_dvd.size() != COL) begin
        fails++;
        $display("FAIL norm%0d_starts: got %0d starts expected %0d", r, st_dvd.size(), COL);
      end
      for (int i = 0; i < COL; i++) begin
        logic [BW-1:0] ed;
        ed = cap(rows[r][i]);
        tests++;
        if (st_dvd[i] !== ed || st_dvs[i] !== dvs[r]) begin
          fails++;
          $display("FAIL norm%0d_start%0d: got (%h,%h) expected (%h,%h)", r, i, st_dvd[i], st_dvs[i], ed, dvs[r]);
        end
        tests++;
        if (o_data[i] !== ans_of(ed, dvs[r]) || o_last[i] !== (i == COL-1)) begin
          fails++;
          $display("FAIL norm%0d_out%0d: got data=%h last=%b expected data=%h last=%b",
                   r, i, o_data[i], o_last[i], ans_of(ed, dvs[r]), (i == COL-1));
        end
      end
    end
  endtask

  // Output stalled for 3 cycles on the first element of a row.
  task automatic test_backpressure();
    row_t          row;
    logic [BW-1:0] d0;
    logic          l0;
    int            guard;
    row = '{20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8};
    clear_queues();
    out_ready = 1'b0;
    send_row(row);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    d0 = out_data;
    l0 = out_last;
    tests++;
    if (out_valid !== 1'b1 || d0 !== ans_of(20'd1, 20'd36) || l0 !== 1'b0) begin
      fails++;
      $display("FAIL bp_first: got valid=%b data=%h last=%b expected valid=1 data=%h last=0",
               out_valid, d0, l0, ans_of(20'd1, 20'd36));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_last !== l0) begin
        fails++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                 k, out_valid, out_data, out_last, d0, l0);
      end
      tests++;
      if (st_dvd.size() != 1 || div_strt !== 1'b0) begin
        fails++;
        $display("FAIL bp_nostart%0d: got starts=%0d strt=%b expected starts=1 strt=0", k, st_dvd.size(), div_strt);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_outs(COL, "bp");
    for (int i = 0; i < COL; i++) begin
      tests++;
      if (o_data[i] !== ans_of(row[i], 20'd36) || o_last[i] !== (i == COL-1)) begin
        fails++;
        $display("FAIL bp_out%0d: got data=%h last=%b expected data=%h last=%b",
                 i, o_data[i], o_last[i], ans_of(row[i], 20'd36), (i == COL-1));
      end
    end
  endtask

  // Divider busy held at ISSUE: start is withheld, then one single pulse.
  task automatic test_busy_hold();
    row_t row;
    row = '{20'd8, 20'd7, 20'd6, 20'd5, 20'd4, 20'd3, 20'd2, 20'd1};
    clear_queues();
    force_busy = 1'b1;
    send_row(row);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (div_strt !== 1'b0 || st_dvd.size() != 0) begin
        fails++;
        $display("FAIL busy_hold%0d: got strt=%b starts=%0d expected strt=0 starts=0", k, div_strt, st_dvd.size());
      end
    end
    @(posedge clk); #1 force_busy = 1'b0;
    @(negedge clk);
    tests++;
    if (div_strt !== 1'b1 || div_dividend !== 20'd8 || div_divisor !== 20'd36) begin
      fails++;
      $display("FAIL busy_release: got strt=%b dvd=%h dvs=%h expected strt=1 dvd=%h dvs=%h",
               div_strt, div_dividend, div_divisor, 20'd8, 20'd36);
    end
    @(negedge clk);
    tests++;
    if (div_strt !== 1'b0) begin
      fails++;
      $display("FAIL busy_single_pulse: got strt=%b expected 0", div_strt);
    end
    wait_outs(COL, "busy");
    for (int i = 0; i < COL; i++) begin
      tests++;
      if (o_data[i] !== ans_of(row[i], 20'd36) || o_last[i] !== (i == COL-1)) begin
        fails++;
        $display("FAIL busy_out%0d: got data=%h last=%b expected data=%h last=%b",
                 i, o_data[i], o_last[i], ans_of(row[i], 20'd36), (i == COL-1));
      end
    end
  endtask

  // Reset during WAIT of the third element, then a fresh row.
  task automatic test_reset_mid_row();
    row_t row_a;
    row_t row_b;
    int   guard;
    row_a = '{20'd10, 20'd20, 20'd30, 20'd40, 20'd50, 20'd60, 20'd70, 20'd80};
    row_b = '{20'd3, 20'd1, 20'd4, 20'd1, 20'd5, 20'd9, 20'd2, 20'd6};
    clear_queues();
    send_row(row_a);
    guard = 0;
    while (st_dvd.size() < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (st_dvd.size() < 3) begin
      fails++;
      $display("FAIL rst_mid_reach: got %0d starts expected 3", st_dvd.size());
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, out_last, div_strt} !== 3'b000 || out_data !== '0 ||
        div_dividend !== '0 || div_divisor !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_outputs: got valid=%b last=%b strt=%b data=%h dvd=%h dvs=%h rdy=%b, expected zeros rdy=1",
               out_valid, out_last, div_strt, out_data, div_dividend, div_divisor, in_ready);
    end
    @(posedge clk); #1;
    clear_queues();
    send_row(row_b);
    wait_outs(COL, "rst_fresh");
    for (int i = 0; i < COL; i++) begin
      tests++;
      if (st_dvd[i] !== row_b[i] || st_dvs[i] !== 20'd31 ||
          o_data[i] !== ans_of(row_b[i], 20'd31) || o_last[i] !== (i == COL-1)) begin
        fails++;
        $display("FAIL rst_fresh%0d: got start=(%h,%h) data=%h last=%b expected start=(%h,%h) data=%h last=%b",
                 i, st_dvd[i], st_dvs[i], o_data[i], o_last[i], row_b[i], 20'd31,
                 ans_of(row_b[i], 20'd31), (i == COL-1));
      end
    end
  endtask

  // Next row offered early: its first element lands the cycle after EMIT->IDLE.
  task automatic test_back_to_back();
    row_t row_a;
    row_t row_b;
    row_a = '{20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8};
    row_b = '{default: 20'd2};
    clear_queues();
    send_row(row_a);
    send_row(row_b);
    wait_outs(2*COL, "b2b");
    tests++;
    if (acc_q.size() < COL+1 || last_q.size() < 1 || acc_q[COL] - last_q[0] != 1) begin
      fails++;
      $display("FAIL b2b_accept_gap: got accepts=%0d gap=%0d expected gap=1",
               acc_q.size(), (acc_q.size() > COL && last_q.size() > 0) ? acc_q[COL] - last_q[0] : -1);
    end
    for (int i = 0; i < 2*COL; i++) begin
      logic [BW-1:0] ev;
      ev = (i < COL) ? ans_of(row_a[i], 20'd36) : ans_of(row_b[i-COL], 20'd16);
      tests++;
      if (o_data[i] !== ev || o_last[i] !== ((i % COL) == COL-1)) begin
        fails++;
        $display("FAIL b2b_out%0d: got data=%h last=%b expected data=%h last=%b",
                 i, o_data[i], o_last[i], ev, ((i % COL) == COL-1));
      end
    end
  endtask

`ifdef SFP_ABS_EN
  // Magnitude capture: -5 and 5 both contribute 5 to the divisor.
  task automatic test_abs();
    row_t row;
    row_t dvd;
    row = '{20'hFFFFB, 20'd5, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0};
    dvd = '{20'd5, 20'd5, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0};
    clear_queues();
    send_row(row);
    wait_outs(COL, "abs");
    for (int i = 0; i < COL; i++) begin
      tests++;
      if (st_dvd[i] !== dvd[i] || st_dvs[i] !== 20'd10 || o_data[i] !== ans_of(dvd[i], 20'd10)) begin
        fails++;
        $display("FAIL abs%0d: got start=(%h,%h) data=%h expected start=(%h,%h) data=%h",
                 i, st_dvd[i], st_dvs[i], o_data[i], dvd[i], 20'd10, ans_of(dvd[i], 20'd10));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normalise();
    test_backpressure();
    test_busy_hold();
    test_reset_mid_row();
    test_back_to_back();
`ifdef SFP_ABS_EN
    test_abs();
`endif
    tests++;
    if (strt_busy_cnt != 0) begin
      fails++;
      $display("FAIL strt_while_busy: got %0d cycles expected 0", strt_busy_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
